mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates a single-port, variable-latency unified memory between two requesters: the instruction-fetch stage (read-only) and the data-memory stage (read/write) of the 5-stage pipeline.
- Sequences each access with a req/ack handshake and latches the address and write data at grant.
- Produces a pipeline stall while any requester is waiting.
- Sits between the PC/IF stage and EX/MEM stage on one side and the memory model on the other.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DM_STREAK, 4, consecutive data grants tolerated while a fetch is pending. Used only with ARB_FAIR_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- if_req_i  in  1  fetch request, level; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched word; valid with if_ack_o, held until the next fetch ack.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- dm_req_i  in  1  data request, level; held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_rdata_o  out  DATA_W  read data; valid with dm_ack_o, held until the next data-read ack.
- dm_ack_o  out  1  one-cycle data completion pulse, for reads and writes.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; sampled in the mem_ack_i cycle.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- stall_o  out  1  pipeline stall.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0: if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_req_o, both acks, busy_o.
  - stall_o follows its combinational equation.
  - Reset mid-access abandons the transfer; no ack is issued.
- States: IDLE, IF_ACC, DM_ACC, RESP.
- IDLE:
  - dm_req_i=1 → DM_ACC. Latch dm_addr_i, dm_we_i, dm_wdata_i into the mem_* registers; mem_req_o=1 from the next cycle.
  - Else if_req_i=1 → IF_ACC. Latch if_addr_i; mem_we_o=0; mem_wdata_o=0.
  - Else stay in IDLE.
- IF_ACC / DM_ACC:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are held constant.
  - On mem_ack_i=1: capture mem_rdata_i into if_data_o (IF) or dm_rdata_o (DM read only), drop mem_req_o, go to RESP.
- RESP:
  - Pulse if_ack_o or dm_ack_o for exactly one cycle, then go to IDLE.
- Latency: req sampled in cycle T; mem_req_o high in T+1; mem_ack_i in T+k (k ≥ 1); ack pulse in T+k+1; arbiter is back in IDLE at T+k+2. Minimum req-to-ack is 2 cycles.
- A requester must deassert or change its request in the cycle after its ack. A req still high in IDLE is treated as a new access.
- mem_ack_i outside IF_ACC/DM_ACC is ignored.
- Changes to input addresses or data after grant have no effect on the access in flight.
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o). This is combinational and is the only combinational output.
- Simultaneous requests in IDLE: data wins. The earlier pipeline instruction must complete first.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A streak counter, width clog2(MAX_DM_STREAK+1), increments on each DM grant made while if_req_i=1.
  - The counter clears on any IF grant, and on any DM grant made while if_req_i=0.
  - When the counter equals MAX_DM_STREAK and both requests are high in IDLE, IF is granted.
  - The counter resets to 0.
- Undefined: strict data priority; no counter logic is present.

Test Plan:
1. Reset with rst_i=1 for 2 cycles while if_req_i=dm_req_i=1 → mem_req_o=0, if_ack_o=dm_ack_o=0, busy_o=0. No mem request is issued before the first cycle after rst_i falls.
2. Single fetch, if_addr_i=0x00000010, mem_ack_i in the first cycle with mem_rdata_i=0x8C220004 → mem_req_o=1 at T+1 with mem_addr_o=0x10 and mem_we_o=0; if_ack_o=1 at T+2 with if_data_o=0x8C220004; stall_o=1 during T..T+1.
3. Simultaneous fetch at 0x20 and data write (addr 0x100, data 0xDEADBEEF) → memory sees write 0x100/0xDEADBEEF with we=1 first; dm_ack_o precedes if_ack_o; the fetch issues 2 cycles after dm_ack_o.
4. Data read with mem_ack_i delayed 5 cycles, changing dm_addr_i mid-access → mem_addr_o stays at the original value; mem_req_o stays high for 5 cycles; stall_o stays high until dm_ack_o; dm_rdata_o equals mem_rdata_i from the ack cycle.
5. rst_i asserted during DM_ACC → next cycle state IDLE and mem_req_o=0; a late mem_ack_i produces no ack.
6. dm_req_i held high across 8 accesses with if_req_i pending, MAX_DM_STREAK=4 → without ARB_FAIR_EN, 8 DM grants and no IF grant; with ARB_FAIR_EN, an IF grant follows the 4th DM ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data memory) for one variable-latency memory port.
// Optional fetch-fairness streak limiter is compiled in when ARB_FAIR_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2,
        RESP   = 2'd3
    } state_t;

    if (MAX_DM_STREAK < 1) begin : g_streak_check
        $error("MAX_DM_STREAK must be at least 1");
    end

    state_t            state_reg, state_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] if_data_reg, if_data_next;
    logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
    logic              if_ack_reg, if_ack_next;
    logic              dm_ack_reg, dm_ack_next;
    logic              busy_reg, busy_next;

    // High when a fetch must win over a simultaneous data request in IDLE.
    logic              grant_if_first;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

    logic [STREAK_W-1:0] streak_reg, streak_next;

    assign grant_if_first = if_req_i && dm_req_i &&
                            (streak_reg == STREAK_W'(MAX_DM_STREAK));

    // Counts data grants that jumped over a waiting fetch.
    always_comb begin
        streak_next = streak_reg;
        if (state_reg == IDLE) begin
            if (dm_req_i && !grant_if_first) begin
                streak_next = if_req_i ? (streak_reg + STREAK_W'(1)) : '0;
            end else if (if_req_i) begin
                streak_next = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end
`else
    assign grant_if_first = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_data_next   = if_data_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dm_req_i && !grant_if_first) begin
                    state_next     = DM_ACC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dm_we_i;
                    mem_addr_next  = dm_addr_i;
                    mem_wdata_next = dm_wdata_i;
                end else if (if_req_i) begin
                    state_next     = IF_ACC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr_i;
                    mem_wdata_next = '0;
                end
            end
            IF_ACC: begin
                if (mem_ack_i) begin
                    if_data_next = mem_rdata_i;
                    mem_req_next = 1'b0;
                    if_ack_next  = 1'b1;
                    state_next   = RESP;
                end
            end
            DM_ACC: begin
                if (mem_ack_i) begin
                    if (!mem_we_reg) begin
                        dm_rdata_next = mem_rdata_i;
                    end
                    mem_req_next = 1'b0;
                    dm_ack_next  = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                // The ack registers were set on entry, so they pulse for this cycle only.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_data_reg   <= '0;
            dm_rdata_reg  <= '0;
            if_ack_reg    <= 1'b0;
            dm_ack_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_data_reg   <= if_data_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_ack_reg    <= if_ack_next;
            dm_ack_reg    <= dm_ack_next;
            busy_reg      <= busy_next;
        end
    end

    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign if_data_o   = if_data_reg;
    assign dm_rdata_o  = dm_rdata_reg;
    assign if_ack_o    = if_ack_reg;
    assign dm_ack_o    = dm_ack_reg;
    assign busy_o      = busy_reg;

    // Any requester still waiting for its ack holds the pipeline.
    assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of arbitration order and response timing.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [AW-1:0] if_addr_i, dm_addr_i;
    logic [DW-1:0] dm_wdata_i, mem_rdata_i;
    logic [DW-1:0] if_data_o, dm_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic          if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, busy_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
    typedef struct {logic is_dm; logic we; logic [DW-1:0] rdata; int cyc;} resp_t;

    acc_t  if_q[$], dm_q[$];
    resp_t resp_q[$];

    int tests = 0, fails = 0, cyc = 0;
    int if_ack_cnt = 0, dm_ack_cnt = 0;
    // Request levels and reset as seen at the most recent rising edge.
    logic snap_if = 1'b0, snap_dm = 1'b0, rst_seen = 1'b1;
    logic idle_seen = 1'b0, expect_req = 1'b0;
    // Memory responder knobs.
    int   mem_lat = 1;
    bit   rand_lat = 1'b0, stray_en = 1'b0, force_ack = 1'b0, use_forced = 1'b0;
    logic [DW-1:0] forced_rdata = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic start_if(input logic [AW-1:0] a);
        if_req_i  = 1'b1;
        if_addr_i = a;
        if_q.push_back('{1'b0, a, '0});
    endtask

    task automatic start_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dm_req_i   = 1'b1;
        dm_we_i    = we;
        dm_addr_i  = a;
        dm_wdata_i = d;
        dm_q.push_back('{we, a, d});
    endtask

    task automatic wait_if_ack(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (if_ack_o) begin
                if_req_i = 1'b0;
                at = cyc;
                return;
            end
        end
        if_req_i = 1'b0;
        fail_now("if_ack_timeout", "got no fetch ack, expected one within 200 cycles");
    endtask

    task automatic wait_dm_ack(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (dm_ack_o) begin
                dm_req_i = 1'b0;
                at = cyc;
                return;
            end
        end
        dm_req_i = 1'b0;
        fail_now("dm_ack_timeout", "got no data ack, expected one within 200 cycles");
    endtask

    // Memory responder: identifies the owner of each new access from the arbitration rules,
    // checks the latched request stays constant, and acks after the chosen latency.
    initial begin
        bit   active, acked, owner_dm;
        int   cnt, lat, streak;
        acc_t cur;
        active = 1'b0; acked = 1'b0; owner_dm = 1'b0; cnt = 0; lat = 1; streak = 0;
        cur = '{1'b0, '0, '0};
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (rst_seen) streak = 0;
            if (!mem_req_o) begin
                if (active && !acked && !rst_seen)
                    fail_now("mem_req_dropped", "request fell before memory ack");
                active = 1'b0;
                if (force_ack || (stray_en && !rst_i && $urandom_range(0, 5) == 0)) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = $urandom;
                    force_ack   = 1'b0;
                end
            end else begin
                if (!active) begin
                    active = 1'b1;
                    acked  = 1'b0;
                    cnt    = 0;
                    lat    = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                    owner_dm = snap_dm && !(FAIR && snap_if && streak == MAXS);
                    if (!snap_dm && !snap_if)
                        fail_now("spurious_grant", "memory request with no requester pending");
                    if (owner_dm) begin
                        if (dm_q.size() == 0) fail_now("dm_grant_unexpected", "no data request queued");
                        else cur = dm_q.pop_front();
                        streak = snap_if ? streak + 1 : 0;
                    end else begin
                        if (if_q.size() == 0) fail_now("if_grant_unexpected", "no fetch request queued");
                        else cur = if_q.pop_front();
                        streak = 0;
                    end
                end
                check("mem_addr", mem_addr_o, cur.addr);
                check("mem_we", mem_we_o, cur.we);
                check("mem_wdata", mem_wdata_o, cur.wdata);
                cnt++;
                if (!acked && cnt == lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = use_forced ? forced_rdata : DW'($urandom);
                    acked       = 1'b1;
                    resp_q.push_back('{owner_dm, cur.we, mem_rdata_i, cyc});
                end
            end
        end
    end

    // Monitor: pops the expected response whenever an ack appears and checks every cycle's outputs.
    initial begin
        resp_t r;
        logic [DW-1:0] exp_if, exp_dm;
        exp_if = '0;
        exp_dm = '0;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_seen) begin
                check("reset_ctrl", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o}, 5'b0);
                check("reset_mem_addr", mem_addr_o, '0);
                check("reset_mem_wdata", mem_wdata_o, '0);
                exp_if = '0;
                exp_dm = '0;
                resp_q.delete();
            end else if (if_ack_o || dm_ack_o) begin
                if (resp_q.size() == 0) begin
                    fail_now("spurious_ack", "ack with no completed memory access");
                end else begin
                    r = resp_q.pop_front();
                    check("ack_owner", {if_ack_o, dm_ack_o}, r.is_dm ? 2'b01 : 2'b10);
                    check("ack_latency", cyc, r.cyc + 1);
                    if (!r.is_dm) exp_if = r.rdata;
                    else if (!r.we) exp_dm = r.rdata;
                    $display("[TB] cycle %0d %s ack we=%0d data=0x%08h", cyc,
                             r.is_dm ? "DM" : "IF", r.we, r.rdata);
                end
                if (if_ack_o) if_ack_cnt++;
                if (dm_ack_o) dm_ack_cnt++;
            end else if (resp_q.size() > 0 && cyc > resp_q[0].cyc + 1) begin
                fail_now("missing_ack", "memory ack was not followed by a requester ack");
                void'(resp_q.pop_front());
            end
            check("if_data", if_data_o, exp_if);
            check("dm_rdata", dm_rdata_o, exp_dm);
            check("stall", stall_o, (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));
            check("busy", busy_o, mem_req_o | if_ack_o | dm_ack_o);
            if (idle_seen) check("grant_timing", mem_req_o, expect_req);
            snap_if    = if_req_i;
            snap_dm    = dm_req_i;
            rst_seen   = rst_i;
            idle_seen  = !busy_o;
            expect_req = !rst_i && (if_req_i || dm_req_i);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ta, tb, base, n;
        rst_i = 1'b1;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;

        // Reset held with both requests raised; data must be served first afterwards.
        start_if(32'h40);
        start_dm(1'b0, 32'h80, '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        fork
            wait_if_ack(ta);
            wait_dm_ack(tb);
        join
        check("reset_dm_before_if", tb < ta, 1'b1);

        // Single fetch with first-cycle memory ack.
        @(negedge clk_i);
        use_forced = 1'b1;
        forced_rdata = 32'h8C220004;
        t0 = cyc;
        start_if(32'h10);
        wait_if_ack(ta);
        check("fetch_req_to_ack", ta - t0, 2);
        check("fetch_data", if_data_o, 32'h8C220004);
        use_forced = 1'b0;

        // Simultaneous fetch and data write.
        @(negedge clk_i);
        start_if(32'h20);
        start_dm(1'b1, 32'h100, 32'hDEADBEEF);
        fork
            wait_if_ack(ta);
            wait_dm_ack(tb);
        join
        check("write_then_fetch_gap", ta - tb, 3);

        // Slow data read with the address changed mid-access.
        @(negedge clk_i);
        mem_lat = 5;
        t0 = cyc;
        start_dm(1'b0, 32'h200, 32'h0);
        fork
            wait_dm_ack(tb);
            begin
                repeat (2) @(negedge clk_i);
                dm_addr_i = 32'h300;
                dm_wdata_i = 32'h12345678;
            end
        join
        check("slow_read_latency", tb - t0, 6);

        // Reset during a data access, then a late memory ack.
        @(negedge clk_i);
        mem_lat = 20;
        base = dm_ack_cnt;
        start_dm(1'b0, 32'h400, '0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        dm_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        force_ack = 1'b1;
        repeat (6) @(negedge clk_i);
        check("abandoned_no_ack", dm_ack_cnt - base, 0);
        mem_lat = 1;

        // Back-to-back data requests with a fetch waiting.
        base = dm_ack_cnt;
        n = -1;
        start_if(32'h500);
        fork
            begin
                wait_if_ack(ta);
                n = dm_ack_cnt - base;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    start_dm(i[0], 32'h600 + 32'(i * 4), $urandom);
                    wait_dm_ack(tb);
                end
            end
        join
        check("dm_grants_before_fetch", n, FAIR ? MAXS : 8);

        // Randomized concurrent traffic with variable latency and stray memory acks.
        rand_lat = 1'b1;
        stray_en = 1'b1;
        fork
            for (int i = 0; i < 60; i++) begin
                int at_if;
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
                start_if({22'h0, 8'($urandom_range(0, 255)), 2'b00});
                wait_if_ack(at_if);
            end
            for (int j = 0; j < 60; j++) begin
                int at_dm;
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
                start_dm(1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
                wait_dm_ack(at_dm);
            end
        join
        stray_en = 1'b0;
        repeat (4) @(negedge clk_i);
        check("queues_drained", if_q.size() + dm_q.size() + resp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
